// File: rtl/bus_dma_pkg.sv
// Shared definitions for the bus DMA master: FSM encoding and default bus widths.
// Shared with the bus, arbiter and decoder so all agree on address/data width.
package bus_dma_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    FIN     = 3'd4
  } dma_state_t;
endpackage

// File: rtl/bus_dma_addr_gen.sv
// Address and word-count bookkeeping for the DMA master: current source and
// destination pointers (wrapping) and the remaining-word counter.
module bus_dma_addr_gen #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_src,
  input  logic [ADDR_W-1:0] i_dst,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_inc_src,
  input  logic              i_commit,
  output logic [ADDR_W-1:0] o_cur_src,
  output logic [ADDR_W-1:0] o_cur_dst,
  output logic              o_last
);
  logic [ADDR_W-1:0] r_cur_src;
  logic [ADDR_W-1:0] r_cur_dst;
  logic [LEN_W-1:0]  r_remaining;

  // A committed write advances the destination and consumes one word together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cur_src   <= '0;
      r_cur_dst   <= '0;
      r_remaining <= '0;
    end else if (i_load) begin
      r_cur_src   <= i_src;
      r_cur_dst   <= i_dst;
      r_remaining <= i_len;
    end else begin
      if (i_inc_src) r_cur_src <= r_cur_src + ADDR_W'(1);
      if (i_commit) begin
        r_cur_dst   <= r_cur_dst + ADDR_W'(1);
        r_remaining <= r_remaining - LEN_W'(1);
      end
    end
  end

  assign o_cur_src = r_cur_src;
  assign o_cur_dst = r_cur_dst;
  assign o_last    = (r_remaining == LEN_W'(1));
endmodule

// File: rtl/bus_dma_master.sv
// Single-channel bus-master copy engine: one read then one write per word.
// Define BUS_DMA_FILL_EN to add fill mode (write a latched pattern, no reads).
module bus_dma_master
  import bus_dma_pkg::*;
#(
  parameter int ADDR_W = bus_dma_pkg::ADDR_W,
  parameter int DATA_W = bus_dma_pkg::DATA_W,
  parameter int LEN_W  = bus_dma_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              fill_mode,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic              m_req,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_dout,
  input  logic              m_grant,
  input  logic [DATA_W-1:0] m_din,
  output logic [2:0]        dbg_state
);
  dma_state_t        r_state;
  logic              w_load;
  logic              w_inc_src;
  logic              w_commit;
  logic [ADDR_W-1:0] w_cur_src;
  logic [ADDR_W-1:0] w_cur_dst;
  logic              w_last;

  assign w_load    = (r_state == IDLE) && start;
  assign w_inc_src = (r_state == RD_DATA);
  assign w_commit  = (r_state == WR) && m_grant;
  assign dbg_state = r_state;

  bus_dma_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_src     (src_addr),
    .i_dst     (dst_addr),
    .i_len     (len),
    .i_inc_src (w_inc_src),
    .i_commit  (w_commit),
    .o_cur_src (w_cur_src),
    .o_cur_dst (w_cur_dst),
    .o_last    (w_last)
  );

`ifdef BUS_DMA_FILL_EN
  logic r_fill;
`else
  logic w_unused_fill;
  assign w_unused_fill = ^{fill_mode, fill_data};
`endif

  // Bus handshake: an access (read or write) is taken on any rising edge where
  // m_req=1 and m_grant=1; while the grant is low every bus output holds. Read
  // data on m_din belongs to the cycle after the granted read. Outputs are
  // registered, so each transition loads the values for the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      m_req     <= 1'b0;
      m_wr      <= 1'b0;
      m_address <= '0;
      m_dout    <= '0;
`ifdef BUS_DMA_FILL_EN
      r_fill    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
`ifdef BUS_DMA_FILL_EN
            r_fill <= fill_mode;
`endif
            if (len == '0) begin
              r_state <= FIN;
              done    <= 1'b1;
`ifdef BUS_DMA_FILL_EN
            end else if (fill_mode) begin
              r_state   <= WR;
              m_req     <= 1'b1;
              m_wr      <= 1'b1;
              m_address <= dst_addr;
              m_dout    <= fill_data;
`endif
            end else begin
              r_state   <= RD_ADDR;
              m_req     <= 1'b1;
              m_address <= src_addr;
            end
          end
        end
        RD_ADDR: begin
          if (m_grant) r_state <= RD_DATA;
        end
        RD_DATA: begin
          r_state   <= WR;
          m_wr      <= 1'b1;
          m_address <= w_cur_dst;
          m_dout    <= m_din;
        end
        WR: begin
          if (m_grant) begin
            if (w_last) begin
              r_state   <= FIN;
              done      <= 1'b1;
              m_req     <= 1'b0;
              m_wr      <= 1'b0;
              m_address <= '0;
              m_dout    <= '0;
`ifdef BUS_DMA_FILL_EN
            end else if (r_fill) begin
              m_address <= m_address + ADDR_W'(1);
`endif
            end else begin
              r_state   <= RD_ADDR;
              m_wr      <= 1'b0;
              m_dout    <= '0;
              m_address <= w_cur_src;
            end
          end
        end
        FIN: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
